wr_ingress: RTL and testbench
=============================

// Module: wr_ingress
// PURPOSE
//  Write-side front end for the async FIFO, in the wclk domain, directly upstream of the write-pointer/full-flag stage.
//  Accepts a valid/ready stream and holds it in a 2-entry skid buffer.
//  Drives winc/wdata into the FIFO write port and never presents a word as written while wfull is high.
//  Optionally computes the write-side fill level and an almost-full flag from the gray write and read pointers.
// PARAMETERS
//  DATA_SIZE  8  width of a data word
//  ADDR_SIZE  4  FIFO address width; depth DEPTH = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits
//  AF_MARGIN  2  almost_full asserts when level >= DEPTH-AF_MARGIN (range 0..DEPTH)
// PORTS
//  wclk       in   1            write clock
//  wrst       in   1            reset: synchronous to wclk, active-high
//  s_valid    in   1            upstream word valid
//  s_ready    out  1            ingress can accept a word
//  s_data     in   DATA_SIZE    upstream word
//  winc       out  1            word on wdata requests a write
//  wdata      out  DATA_SIZE    word to FIFO memory
//  wfull      in   1            registered full flag from the write-pointer stage
//  wptr       in   ADDR_SIZE+1  gray write pointer from the write-pointer stage
//  wq2_rptr   in   ADDR_SIZE+1  gray read pointer, already synchronised into wclk
//  level      out  ADDR_SIZE+1  words in FIFO, as seen from the write side
//  almost_full out 1            level >= DEPTH-AF_MARGIN
// BEHAVIOUR
//  Reset (wrst=1 at a wclk edge):
//   - count=0; s_ready=0 during reset, 1 in the first cycle after.
//   - winc=0, wdata=0, level=0, almost_full=0.
//   - Reset mid-transfer discards both buffered words; nothing is replayed.
//  Skid buffer: two registers, head (H) and tail (T), plus count in {0,1,2}; states EMPTY / ONE / TWO.
//   - accept = s_valid & s_ready.
//   - drain  = winc & ~wfull.
//   - s_ready = (count!=2), from registered state only; no combinational path from wfull or s_valid.
//   - winc = (count!=0); wdata = H. Both are register-driven.
//  Transitions:
//   - EMPTY + accept -> ONE, H<=s_data.
//   - ONE + accept & ~drain -> TWO, T<=s_data.
//   - ONE + accept & drain -> ONE, H<=s_data.
//   - ONE + drain & ~accept -> EMPTY.
//   - TWO + drain -> ONE, H<=T.
//   - TWO accepts nothing because s_ready=0.
//   - No event -> hold state.
//  Latency: a word accepted at edge N is on wdata with winc=1 in the cycle after N.
//   - It is written at edge N+1 if wfull=0 then.
//   - Sustained throughput is 1 word/cycle while wfull=0.
//  wfull high: winc stays high and H is held stable until wfull drops; order is preserved, no loss, no duplication.
//  wptr/wq2_rptr are sampled as-is; no synchronisation is done here.
// CONFIGURATION
//  Macro WR_LEVEL_EN.
//  Defined:
//   - wb = gray2bin(wptr), rb = gray2bin(wq2_rptr).
//   - level <= wb - rb, modulo 2**(ADDR_SIZE+1), registered; one cycle latency from the pointer inputs.
//   - almost_full <= (wb-rb) >= DEPTH-AF_MARGIN, registered in the same cycle as level.
//   - Level may read high because of read-pointer sync lag; it is never low.
//  Undefined: level and almost_full are tied to 0 and no pointer logic is built.
//  The skid buffer behaves identically either way.
// TESTING
//  1. Reset: assert wrst 3 cycles with s_valid=1 -> s_ready=0, winc=0, level=0 throughout; s_ready=1 the cycle after release.
//  2. Stream: s_data 0x01..0x10 back-to-back, wfull=0 -> winc=1 from cycle 1.
//     - wdata sequence 0x01..0x10, one word per cycle.
//     - s_ready stays 1.
//  3. Backpressure: send 0xA0,0xA1,0xA2 with wfull=1 from the start.
//     - Count reaches 2, s_ready=0, wdata=0xA0 held.
//     - Release wfull -> writes 0xA0, 0xA1, then 0xA2 on consecutive cycles; nothing lost or duplicated.
//  4. Reset mid-operation: count=2 (0xB0,0xB1) with wfull=1; pulse wrst for 1 cycle -> winc=0 the next cycle; 0xB0/0xB1 never written.
//  5. WR_LEVEL_EN, ADDR_SIZE=4, AF_MARGIN=2:
//     - wptr=gray(14), wq2_rptr=gray(0) -> level=14, almost_full=1.
//     - wptr=gray(3), wq2_rptr=gray(29) (wrap) -> level=6, almost_full=0.
//  6. WR_LEVEL_EN undefined, same stimulus as 5 -> level=0, almost_full=0.

Source files
------------

// File: rtl/wr_ingress.sv
// wr_ingress: write-side front end for the async FIFO (wclk domain).
// A 2-entry skid buffer (head/tail) takes a valid/ready stream and presents
// words to the FIFO write port as winc/wdata. A word is not counted as written
// while wfull is high.
// Optional feature macro: WR_LEVEL_EN. When defined, a registered fill level
// and almost-full flag are built from the gray write/read pointers. When
// undefined, level and almost_full are tied to 0.
//
// Handshake: upstream transfers a word on a wclk edge where s_valid & s_ready.
// s_ready comes only from registered state. Downstream treats a word as
// written on an edge where winc & ~wfull. While wfull is high, winc and wdata
// hold steady.
module wr_ingress #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 winc,
  output logic [DATA_SIZE-1:0] wdata,
  input  logic                 wfull,
  input  logic [ADDR_SIZE:0]   wptr,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic [ADDR_SIZE:0]   level,
  output logic                 almost_full,
  output logic [1:0]           dbg_state
);

  // The state encoding doubles as the buffer occupancy count (0, 1 or 2).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;
  logic                 winc_q, winc_d;
  logic                 s_ready_q, s_ready_d;
  logic                 accept;
  logic                 drain;

  assign accept    = s_valid & s_ready_q;
  assign drain     = winc_q & ~wfull;
  assign s_ready   = s_ready_q;
  assign winc      = winc_q;
  assign wdata     = head_q;
  assign dbg_state = state_q;

  // Next-state and data movement for the skid buffer; outputs follow the next state.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          head_d  = s_data;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          head_d = s_data;
        end else if (accept) begin
          state_d = ST_TWO;
          tail_d  = s_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    s_ready_d = (state_d != ST_TWO);
    winc_d    = (state_d != ST_EMPTY);
  end

  // Register buffer state; reset drops any buffered words and holds off upstream.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q   <= ST_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      winc_q    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      winc_q    <= winc_d;
      s_ready_q <= s_ready_d;
    end
  end

`ifdef WR_LEVEL_EN
  localparam int DEPTH  = 1 << ADDR_SIZE;
  localparam int AF_INT = DEPTH - AF_MARGIN;
  localparam logic [ADDR_SIZE:0] AF_THRESH = AF_INT[ADDR_SIZE:0];

  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_SIZE:0] level_q, level_d;
  logic               af_q, af_d;

  // Fill level from pointer difference. It can only overstate, because the read pointer lags.
  always_comb begin
    level_d = gray2bin(wptr) - gray2bin(wq2_rptr);
    af_d    = (level_d >= AF_THRESH);
  end

  // Register level and almost-full together, one cycle behind the pointers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign level       = level_q;
  assign almost_full = af_q;
`else
  logic unused_ptrs;
  assign unused_ptrs = ^{wptr, wq2_rptr};
  assign level       = '0;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ingress.sv
// Directed bench for wr_ingress: reset, streaming, backpressure, mid-transfer
// reset, and level/almost_full (checked against the build's WR_LEVEL_EN setting).
module tb_wr_ingress;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull;
  logic [AW:0]   wptr;
  logic [AW:0]   wq2_rptr;
  logic [AW:0]   level;
  logic          almost_full;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_log[$];

  wr_ingress #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .AF_MARGIN(2)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .winc        (winc),
    .wdata       (wdata),
    .wfull       (wfull),
    .wptr        (wptr),
    .wq2_rptr    (wq2_rptr),
    .level       (level),
    .almost_full (almost_full),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 wclk = ~wclk;

  initial begin
    #20000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Write monitor: a word shown with winc & ~wfull at mid-cycle is written at the next edge
  always @(negedge wclk) begin
    if (!wrst && winc && !wfull) wr_log.push_back(wdata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst = 1'b1; s_valid = 1'b1; s_data = 8'h00; wfull = 1'b0;
    wptr = '0; wq2_rptr = '0;

    // 1. Reset held 3 cycles with s_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_s_ready", s_ready, 0);
      check("rst_winc", winc, 0);
      check("rst_level", level, 0);
      check("rst_wdata", wdata, 0);
    end
    s_valid = 1'b0;
    wrst = 1'b0;
    tick();
    check("rel_s_ready", s_ready, 1);
    check("rel_winc", winc, 0);
    check("rel_state", dbg_state, 0);

    // 2. Back-to-back stream 0x01..0x10 with wfull low
    s_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_data = i[7:0];
      tick();
      check("str_winc", winc, 1);
      check("str_wdata", wdata, i);
      check("str_s_ready", s_ready, 1);
      exp_q.push_back(i[7:0]);
    end
    s_valid = 1'b0;
    tick();
    check("str_end_winc", winc, 0);

    // 3. Backpressure: three words with wfull high
    wfull = 1'b1;
    s_valid = 1'b1; s_data = 8'hA0;
    tick();
    check("bp1_wdata", wdata, 8'hA0);
    check("bp1_s_ready", s_ready, 1);
    s_data = 8'hA1;
    tick();
    check("bp2_state", dbg_state, 2);
    check("bp2_s_ready", s_ready, 0);
    check("bp2_wdata", wdata, 8'hA0);
    s_data = 8'hA2;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_hold_s_ready", s_ready, 0);
      check("bp_hold_winc", winc, 1);
      check("bp_hold_wdata", wdata, 8'hA0);
    end
    wfull = 1'b0;
    tick();
    check("bp_rel1_wdata", wdata, 8'hA1);
    check("bp_rel1_s_ready", s_ready, 1);
    tick();
    check("bp_rel2_wdata", wdata, 8'hA2);
    check("bp_rel2_winc", winc, 1);
    s_valid = 1'b0;
    tick();
    check("bp_end_winc", winc, 0);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);

    // 4. Reset with two words buffered and wfull high
    wfull = 1'b1;
    s_valid = 1'b1; s_data = 8'hB0;
    tick();
    s_data = 8'hB1;
    tick();
    check("mr_state", dbg_state, 2);
    s_valid = 1'b0;
    wrst = 1'b1;
    tick();
    check("mr_winc", winc, 0);
    check("mr_s_ready", s_ready, 0);
    wrst = 1'b0;
    wfull = 1'b0;
    tick();
    check("mr_post_winc", winc, 0);
    check("mr_post_s_ready", s_ready, 1);
    tick();
    check("mr_post2_winc", winc, 0);

    // 5/6. Level and almost_full from gray pointers
    wptr = 5'd9;  wq2_rptr = 5'd0;   // gray(14), gray(0)
    tick();
`ifdef WR_LEVEL_EN
    check("lvl14", level, 14);
    check("af14", almost_full, 1);
`else
    check("lvl14_off", level, 0);
    check("af14_off", almost_full, 0);
`endif
    wptr = 5'd11; wq2_rptr = 5'd0;   // gray(13), gray(0)
    tick();
`ifdef WR_LEVEL_EN
    check("lvl13", level, 13);
    check("af13", almost_full, 0);
`else
    check("lvl13_off", level, 0);
    check("af13_off", almost_full, 0);
`endif
    wptr = 5'd2;  wq2_rptr = 5'd19;  // gray(3), gray(29): wrap
    tick();
`ifdef WR_LEVEL_EN
    check("lvl_wrap", level, 6);
    check("af_wrap", almost_full, 0);
`else
    check("lvl_wrap_off", level, 0);
    check("af_wrap_off", almost_full, 0);
`endif

    // Scoreboard: every written word in order, none lost or duplicated
    check("wr_count", wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_log.size()) check("wr_word", wr_log[i], exp_q[i]);
      else check("wr_word_missing", 32'hFFFF_FFFF, exp_q[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
